iir_filter: RTL and testbench

Fixed-point, second-order low-pass IIR filter: two identical cascaded first-order leaky-integrator sections with unity DC gain. It sits in the sample-rate datapath, takes one signed sample per clock and produces one filtered signed sample per clock. Its job is to pass slow signal content unchanged and suppress content near 0.01·fs and above.

---
 rtl/iir_pkg.sv | 29 ++
 rtl/iir_lp1.sv | 38 +++
 rtl/iir_filter.sv | 46 ++++
 tb/tb_iir_filter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared constants and output helper for the second-order low-pass IIR.
// Sections keep W+F bit state; the output is rounded back to W bits.
package iir_pkg;

    localparam int W_DEF = 8;
    localparam int K_DEF = 5;
    localparam int F_DEF = 8;

    // Round half up by f fractional bits, then clamp to a w-bit signed range.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] v,
        input int                 f,
        input int                 w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (v + (64'sd1 <<< (f - 1))) >>> f;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_lp1.sv
// One first-order leaky-integrator section with unity DC gain.
// The input is scaled by 2^F into an IN_W+F bit state.
module iir_lp1
    import iir_pkg::*;
#(
    parameter int IN_W = W_DEF,
    parameter int K    = K_DEF,
    parameter int F    = F_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [IN_W-1:0]    in,
    output logic signed [IN_W+F-1:0]  state
);

    localparam int SW = IN_W + F;

    logic signed [SW-1:0] r_state;
    logic signed [SW-1:0] w_in_s;
    logic signed [SW:0]   w_diff;
    logic signed [SW:0]   w_step;

    assign w_in_s = SW'(in) <<< F;
    // One guard bit keeps the difference exact before the arithmetic shift.
    assign w_diff = (SW + 1)'(w_in_s) - (SW + 1)'(r_state);
    assign w_step = w_diff >>> K;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= '0;
        end else begin
            r_state <= r_state + SW'(w_step);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/iir_filter.sv
// Second-order low-pass IIR: two cascaded first-order sections.
// Output is a registered-state function only; rst_n is active-high async.
module iir_filter
    import iir_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int K = K_DEF,
    parameter int F = F_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    localparam int SW = W + F;

    logic signed [SW-1:0] w_s1;
    logic signed [SW-1:0] w_s2;

    iir_lp1 #(
        .IN_W (W),
        .K    (K),
        .F    (F)
    ) u_sec1 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (x),
        .state (w_s1)
    );

    // Section 2 takes the already-scaled state, so it adds no further scaling.
    iir_lp1 #(
        .IN_W (SW),
        .K    (K),
        .F    (0)
    ) u_sec2 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (w_s1),
        .state (w_s2)
    );

    assign y = W'(sat_round(64'(w_s2), F, W));

endmodule

// File: tb/tb_iir_filter.sv
// Directed bench for iir_filter: reset, steps, extremes, rejection.
// Step targets come from a table; sine tests check bounded error.
module tb_iir_filter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic signed [7:0] x = '0;
    logic signed [7:0] y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x;
        int n;
        int exp;
    } vec_t;

    vec_t tv[9];

    iir_filter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  prev;
        int  ylast;
        int  lo;
        int  hi;
        int  viol;
        int  peak;
        int  err;
        int  rf;
        real pi;
        real xr;

        pi = 3.14159265358979;

        tv[0] = '{64,   1500, 64};
        tv[1] = '{127,  1500, 127};
        tv[2] = '{-128, 1500, -128};
        tv[3] = '{127,  1500, 127};
        tv[4] = '{0,    1500, 0};
        tv[5] = '{50,   1500, 50};
        tv[6] = '{-50,  1500, -50};
        tv[7] = '{1,    1500, 1};
        tv[8] = '{-1,   1500, -1};

        #1;
        chk("reset_y0", int'(y), 0);
        for (int i = 0; i < 10; i++) begin
            x = (i % 2 == 1) ? -8'sd100 : 8'sd100;
            edge1();
            chk("rst_hold", int'(y), 0);
        end
        x = '0;
        rst_n = 1'b0;

        prev = 0;
        for (int v = 0; v < 9; v++) begin
            x = 8'(tv[v].x);
            lo = (prev < tv[v].x) ? prev : tv[v].x;
            hi = (prev < tv[v].x) ? tv[v].x : prev;
            ylast = prev;
            viol = 0;
            for (int c = 1; c <= tv[v].n; c++) begin
                edge1();
                if (c <= 2) begin
                    chk($sformatf("latency v%0d e%0d", v, c), int'(y), prev);
                end
                if (int'(y) < lo || int'(y) > hi) viol++;
                if (tv[v].x > prev && int'(y) < ylast) viol++;
                if (tv[v].x < prev && int'(y) > ylast) viol++;
                ylast = int'(y);
            end
            chk($sformatf("monotonic v%0d", v), viol, 0);
            chk($sformatf("settle v%0d", v), int'(y), tv[v].exp);
            for (int c = 0; c < 20; c++) begin
                edge1();
                if (int'(y) != tv[v].exp) viol++;
            end
            chk($sformatf("stable v%0d", v), viol, 0);
            prev = tv[v].exp;
        end

        x = 8'sd64;
        for (int c = 0; c < 200; c++) edge1();
        chk("pre_rst_nonzero", (y != 0) ? 1 : 0, 1);
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_rst", int'(y), 0);
        viol = 0;
        for (int c = 0; c < 3; c++) begin
            edge1();
            if (y != 0) viol++;
        end
        chk("rst_held_clk", viol, 0);
        rst_n = 1'b0;
        edge1();
        chk("post_rst_e1", int'(y), 0);
        edge1();
        chk("post_rst_e2", int'(y), 0);

        rst_n = 1'b1;
        edge1();
        x = '0;
        rst_n = 1'b0;
        peak = 0;
        for (int n = 0; n < 2000; n++) begin
            x = 8'(int'(16.0 * $sin(2.0 * pi * 0.01 * n)));
            edge1();
            if (n >= 500) begin
                if (int'(y) > peak) peak = int'(y);
                if (-int'(y) > peak) peak = -int'(y);
            end
        end
        total++;
        if (peak > 4) begin
            bad++;
            $display("FAIL hf_reject: peak |y| %0d above limit 4", peak);
        end

        rst_n = 1'b1;
        edge1();
        x = '0;
        rst_n = 1'b0;
        peak = 0;
        for (int n = 0; n < 10000; n++) begin
            xr = 64.0 * $sin(2.0 * pi * 0.0001 * n)
               + 16.0 * $sin(2.0 * pi * 0.01 * n);
            x = 8'(int'(xr));
            edge1();
            if (n >= 500) begin
                rf = int'(64.0 * $sin(2.0 * pi * 0.0001 * (n - 64)));
                err = int'(y) - rf;
                if (err < 0) err = -err;
                if (err > peak) peak = err;
            end
        end
        total++;
        if (peak > 5) begin
            bad++;
            $display("FAIL composite: peak error %0d above limit 5", peak);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
